// File: rtl/roba_pkg.sv
// roba_pkg: shared definitions for the ROBA multiplier pipeline.
//   roba_mode_e : product mode select (approximate ROBA or exact)
//   ROBA_LAT    : cycles from input acceptance to result with out_ready held high
package roba_pkg;

  typedef enum logic {
    MODE_APPROX = 1'b0,
    MODE_EXACT  = 1'b1
  } roba_mode_e;

  localparam int unsigned ROBA_LAT = 3;

endpackage

// File: rtl/roba_round.sv
// roba_round: rounds an unsigned magnitude to the nearest power of two.
//   mag_i   : operand magnitude
//   ar_o    : rounded value Ar (WIDTH+1 bits, 0 when mag_i is 0)
//   shift_o : log2(Ar), meaningless when mag_i is 0
module roba_round #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] mag_i,
  output logic [WIDTH:0]   ar_o,
  output logic [SW-1:0]    shift_o
);

  logic [SW-1:0] lead;
  logic          below;
  logic          round_up;

  always_comb begin
    lead  = '0;
    below = 1'b0;
    // Highest set bit wins; also remember the bit just beneath it.
    for (int unsigned i = 1; i < WIDTH; i++) begin
      if (mag_i[i]) begin
        lead  = SW'(i);
        below = mag_i[i-1];
      end
    end
    round_up = below && (lead >= SW'(2));
    shift_o  = lead + SW'(round_up);
    ar_o     = (mag_i == '0) ? '0 : ((WIDTH + 1)'(1) << shift_o);
  end

endmodule

// File: rtl/roba_mult_pipe.sv
// roba_mult_pipe: three-stage valid/ready multiplier, approximate (ROBA) or exact.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake carrying x, y, tc, mode
//   out_valid/out_ready : output handshake carrying p
//   S1 magnitude/round, S2 shift/add (+ exact product), S3 subtract/sign into p.
module roba_mult_pipe
  import roba_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               tc,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned SW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  // Stage valid bits and handshake
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic in_fire, adv1, adv2, adv3;

  assign adv3      = v3_q & out_ready;
  assign adv2      = v2_q & (~v3_q | out_ready);
  assign adv1      = v1_q & (~v2_q | adv2);
  assign in_ready  = ~v1_q | adv1;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = v3_q;

  always_comb begin
    v1_d = in_fire ? 1'b1 : (adv1 ? 1'b0 : v1_q);
    v2_d = adv1    ? 1'b1 : (adv2 ? 1'b0 : v2_q);
    v3_d = adv2    ? 1'b1 : (adv3 ? 1'b0 : v3_q);
  end

  // S1: magnitudes and rounding
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   x_ar, y_ar;
  logic [SW-1:0]    x_sh, y_sh;

  assign x_mag = (tc && x[WIDTH-1]) ? -x : x;
  assign y_mag = (tc && y[WIDTH-1]) ? -y : y;

  roba_round #(.WIDTH(WIDTH), .SW(SW)) u_round_x (
    .mag_i   (x_mag),
    .ar_o    (x_ar),
    .shift_o (x_sh)
  );

  roba_round #(.WIDTH(WIDTH), .SW(SW)) u_round_y (
    .mag_i   (y_mag),
    .ar_o    (y_ar),
    .shift_o (y_sh)
  );

  logic [WIDTH-1:0] s1_xm_q, s1_xm_d, s1_ym_q, s1_ym_d;
  logic [WIDTH:0]   s1_xr_q, s1_xr_d;
  logic [SW-1:0]    s1_sx_q, s1_sx_d, s1_sy_q, s1_sy_d;
  logic             s1_zx_q, s1_zx_d, s1_zy_q, s1_zy_d;
  logic             s1_neg_q, s1_neg_d;
  roba_mode_e       s1_mode_q, s1_mode_d;

  always_comb begin
    s1_xm_d   = s1_xm_q;
    s1_ym_d   = s1_ym_q;
    s1_xr_d   = s1_xr_q;
    s1_sx_d   = s1_sx_q;
    s1_sy_d   = s1_sy_q;
    s1_zx_d   = s1_zx_q;
    s1_zy_d   = s1_zy_q;
    s1_neg_d  = s1_neg_q;
    s1_mode_d = s1_mode_q;
    if (in_fire) begin
      s1_xm_d   = x_mag;
      s1_ym_d   = y_mag;
      s1_xr_d   = x_ar;
      s1_sx_d   = x_sh;
      s1_sy_d   = y_sh;
      s1_zx_d   = (x_ar == '0);
      s1_zy_d   = (y_ar == '0);
      s1_neg_d  = tc & (x[WIDTH-1] ^ y[WIDTH-1]);
      s1_mode_d = roba_mode_e'(mode);
    end
  end

  // S2: shift/add terms and exact product
  logic [PW-1:0] s2_p_q, s2_p_d, s2_z_q, s2_z_d, s2_prod_q, s2_prod_d;
  logic          s2_neg_q, s2_neg_d;
  roba_mode_e    s2_mode_q, s2_mode_d;
  logic [PW-1:0] term_a, term_b, term_z;

  always_comb begin
    // A zero operand has no rounding, so every term touching it is dropped.
    term_a = s1_zx_q ? '0 : (PW'(s1_ym_q) << s1_sx_q);
    term_b = s1_zy_q ? '0 : (PW'(s1_xm_q) << s1_sy_q);
    term_z = (s1_zx_q | s1_zy_q) ? '0 : (PW'(s1_xr_q) << s1_sy_q);
    s2_p_d    = s2_p_q;
    s2_z_d    = s2_z_q;
    s2_prod_d = s2_prod_q;
    s2_neg_d  = s2_neg_q;
    s2_mode_d = s2_mode_q;
    if (adv1) begin
      s2_p_d    = term_a + term_b;
      s2_z_d    = term_z;
      s2_prod_d = PW'(s1_xm_q) * PW'(s1_ym_q);
      s2_neg_d  = s1_neg_q;
      s2_mode_d = s1_mode_q;
    end
  end

  // S3: subtract/select and sign into the output register
  logic [PW-1:0] m_val, p_q, p_d;

  always_comb begin
    m_val = (s2_mode_q == MODE_EXACT) ? s2_prod_q : (s2_p_q - s2_z_q);
    p_d   = p_q;
    if (adv2) begin
      p_d = (s2_neg_q && (m_val != '0)) ? -m_val : m_val;
    end
  end

  assign p = p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      p_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      p_q  <= p_d;
    end
  end

  // Data path without reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    s1_xm_q   <= s1_xm_d;
    s1_ym_q   <= s1_ym_d;
    s1_xr_q   <= s1_xr_d;
    s1_sx_q   <= s1_sx_d;
    s1_sy_q   <= s1_sy_d;
    s1_zx_q   <= s1_zx_d;
    s1_zy_q   <= s1_zy_d;
    s1_neg_q  <= s1_neg_d;
    s1_mode_q <= s1_mode_d;
    s2_p_q    <= s2_p_d;
    s2_z_q    <= s2_z_d;
    s2_prod_q <= s2_prod_d;
    s2_neg_q  <= s2_neg_d;
    s2_mode_q <= s2_mode_d;
  end

endmodule

// File: tb/tb_roba_mult_pipe.sv
module tb_roba_mult_pipe;
  import roba_pkg::*;

  localparam int unsigned W = 16;

  logic           clk, rst_n;
  logic           in_valid, in_ready, tc, mode, out_valid, out_ready;
  logic [W-1:0]   x, y;
  logic [2*W-1:0] p;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_out    = 0;

  longint unsigned exp_q[$];
  logic            held_v = 1'b0;
  logic [2*W-1:0]  held_p;

  roba_mult_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .tc        (tc),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: power-of-two rounding of a magnitude.
  function automatic longint unsigned ar_of(input longint unsigned a);
    int k;
    if (a == 0) return 0;
    k = 0;
    for (int i = 0; i < W; i++) if (a[i]) k = i;
    if (k >= 2 && a[k-1]) return 64'd1 << (k + 1);
    return 64'd1 << k;
  endfunction

  function automatic longint unsigned model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                            input logic tcv, input logic modev);
    longint unsigned ax, ay, xr, yr, m, mask;
    mask = (64'd1 << (2 * W)) - 1;
    ax = (tcv && xv[W-1]) ? ((64'd1 << W) - xv) : 64'(xv);
    ay = (tcv && yv[W-1]) ? ((64'd1 << W) - yv) : 64'(yv);
    xr = ar_of(ax);
    yr = ar_of(ay);
    if (modev) m = (ax * ay) & mask;
    else       m = (ay * xr + ax * yr - xr * yr) & mask;
    if (tcv && (xv[W-1] ^ yv[W-1]) && m != 0) m = ((64'd1 << (2 * W)) - m) & mask;
    return m;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return W'($urandom_range(0, 7));
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(x, y, tc, mode));
        n_acc++;
      end
      if (out_valid && !out_ready) begin
        if (held_v) check_eq("stall_hold", p, held_p);
        held_v = 1'b1;
        held_p = p;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check_eq("sb_p", p, exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  task automatic run_one(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic tcv, input logic modev, input logic [63:0] exp);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; x = xv; y = yv; tc = tcv; mode = modev;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(ROBA_LAT));
    check_eq(tag, 64'(p), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc0, out0, guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; tc = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_p", 64'(p), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors
    run_one("x6y6_approx", 16'd6, 16'd6, 1'b1, 1'b0, 64'h20);
    run_one("x6y6_exact", 16'd6, 16'd6, 1'b1, 1'b1, 64'd36);
    run_one("xm6y6_approx", 16'hFFFA, 16'd6, 1'b1, 1'b0, 64'hFFFF_FFE0);
    run_one("x3y3_approx", 16'd3, 16'd3, 1'b1, 1'b0, 64'd8);
    run_one("x0ym5_approx", 16'd0, 16'hFFFB, 1'b1, 1'b0, 64'd0);
    run_one("minneg_approx", 16'h8000, 16'h8000, 1'b1, 1'b0, 64'h4000_0000);
    run_one("minneg_exact", 16'h8000, 16'h8000, 1'b1, 1'b1, 64'h4000_0000);
    run_one("max_uns_exact", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 64'hFFFE_0001);

    // Stall: six beats into a blocked output
    out_ready = 1'b0;
    acc0 = n_acc;
    out0 = n_out;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          @(posedge clk); #1;
          in_valid = 1'b1; x = W'(i * 37); y = W'(i + 100); tc = 1'b0; mode = 1'b1;
          guard = 0;
          @(negedge clk);
          while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 50) check_eq("stream_accept_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check_eq("stall_in_ready", 64'(in_ready), 64'd0);
        check_eq("stall_accepts", 64'(n_acc - acc0), 64'd3);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while ((n_out - out0) < 6 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("stream_out_count", 64'(n_out - out0), 64'd6);

    // Reset one cycle before the first result would appear
    @(posedge clk); #1;
    in_valid = 1'b1; x = 16'd100; y = 16'd200; tc = 1'b0; mode = 1'b1;
    @(posedge clk); #1;
    x = 16'd7; y = 16'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_p", 64'(p), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out0 = n_out;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("postrst_no_out", 64'(out_valid), 64'd0);
    end
    check_eq("postrst_out_count", 64'(n_out - out0), 64'd0);
    run_one("postrst_beat", 16'd12, 16'd11, 1'b0, 1'b1, 64'd132);

    // Random regression with random back-pressure
    acc0 = n_acc;
    guard = 0;
    while ((n_acc - acc0) < 300 && guard < 3000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      x         = rnd_op();
      y         = rnd_op();
      tc        = 1'($urandom_range(0, 1));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    check_eq("rand_accepts", 64'(n_acc - acc0 >= 300), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/roba_mult_pipe.md
ROBA_MULT_PIPE -- requirements
Module: roba_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock for every register in the block.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block accepts the beat this cycle.
REQ-006 x  input  WIDTH  multiplicand.
REQ-007 y  input  WIDTH  multiplier.
REQ-008 tc  input  1  1 = operands are two's complement; 0 = unsigned.
REQ-009 mode  input  1  0 = approximate ROBA product; 1 = exact product.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 p  output  2*WIDTH  product, two's complement if tc=1, else unsigned.

Function
REQ-013 A beat transfers on the input when in_valid and in_ready are both 1; on the output when out_valid and out_ready are both 1.
REQ-014 The pipeline has three stages (S1 abs/round/encode, S2 shift/add, S3 subtract/sign); with out_ready held at 1, the result appears 3 cycles after acceptance, at 1 beat per cycle.
REQ-015 Each stage holds one valid bit. A stage loads when it is empty or its contents advance in the same cycle. in_ready = NOT S1.valid OR S1 advances; it is purely combinational from stage state and out_ready.
REQ-016 With out_ready at 0, the pipe fills to 3 beats. in_ready then drops, and no beat is lost, duplicated or reordered.
REQ-017 tc, mode, x and y are captured at acceptance and travel with the beat; changing them mid-flight never affects earlier beats.
REQ-018 S1 magnitude: |a| = two's-complement negation of a when tc=1 and a[WIDTH-1]=1; otherwise |a| = a. |a| is WIDTH bits; the most-negative value maps to 2^(WIDTH-1).
REQ-019 S1 rounding uses k = leading-one position of |a|. Ar = 2^(k+1) if k>=2 and bit k-1 is set; else Ar = 2^k. Ar = 0 for |a| = 0. The encoded shift is log2(Ar).
REQ-020 S2 forms P = (|y| << log2 Xr) + (|x| << log2 Yr) and Z = Xr << log2 Yr, each 2*WIDTH bits wide, with zero-operand terms forced to 0.
REQ-021 S3, mode=0: M = P - Z, a true 2*WIDTH-bit subtraction with no bitwise approximation.
REQ-022 S3, mode=1: M = |x| * |y| exactly; the exact product is computed across S2/S3 so latency is identical to mode 0.
REQ-023 Sign: when tc=1 and x[MSB] XOR y[MSB] = 1 and M != 0, p = two's-complement negation of M (never one's complement); otherwise p = M.
REQ-024 p is registered and holds stable while out_valid=1 and out_ready=0.

Reset
REQ-025 While rst_n=0, all stage valid bits are 0, out_valid=0, p=0, and in_ready=1 once rst_n returns high.
REQ-026 Reset asserted mid-operation discards every in-flight beat. No output beat appears for beats accepted before reset.
REQ-027 Data-path registers other than p need no reset; valid bits gate them.

Structure
REQ-028 Shared package roba_pkg holds the mode encodings (MODE_APPROX=0, MODE_EXACT=1) and the constant ROBA_LAT=3.
REQ-029 One sub-module, roba_round, parametrised by WIDTH, maps |a| to {Ar, shift code}; it is instantiated twice in S1.

Verification
REQ-030 WIDTH=16, tc=1, mode=0, x=6, y=6 -> p=32 (0x00000020) after 3 cycles; same with mode=1 -> p=36.
REQ-031 tc=1, mode=0, x=-6, y=6 -> p=0xFFFFFFE0; x=3, y=3 -> p=8; x=0, y=-5 -> p=0.
REQ-032 tc=1, x=y=0x8000 (-32768), mode=0 and mode=1 -> p=0x40000000 both; tc=0, mode=1, x=y=0xFFFF -> p=0xFFFE0001.
REQ-033 Stream beats 1..6 with out_ready=0 for cycles 1..8 then 1 -> in_ready low after 3 accepts; outputs in order, none lost or duplicated; p stable while stalled.
REQ-034 Accept 2 beats, pulse rst_n low 1 cycle before first output -> out_valid stays 0 and no stale result ever emerges; the next accepted beat returns correctly after 3 cycles.
REQ-035 Random regression vs a reference model of REQ-018..023 over both modes, both tc values and random out_ready: zero mismatches.
